// File: rtl/bcd_7seg_scan_if.sv
// Display bus for bcd_7seg_scan: load strobe, BCD word, segment/anode scan outputs.
// Decimal-point lines exist only when BCD_7SEG_SCAN_DP_EN is defined.
interface bcd_7seg_scan_if #(
  parameter int N_DIGITS = 4
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                    load;
  logic [4*N_DIGITS-1:0]   bcd_in;
  logic [6:0]              seg;
  logic [N_DIGITS-1:0]     an;
  logic [IW-1:0]           digit_idx;
`ifdef BCD_7SEG_SCAN_DP_EN
  logic [N_DIGITS-1:0]     dp_in;
  logic                    dp;

  modport master (
    output load, bcd_in, dp_in,
    input  seg, an, digit_idx, dp
  );
  modport slave (
    input  load, bcd_in, dp_in,
    output seg, an, digit_idx, dp
  );
`else
  modport master (
    output load, bcd_in,
    input  seg, an, digit_idx
  );
  modport slave (
    input  load, bcd_in,
    output seg, an, digit_idx
  );
`endif
endinterface

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed BCD to 7-segment scan driver with blanking and LZB.
// Optional decimal points: define BCD_7SEG_SCAN_DP_EN.
module bcd_7seg_scan #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 1,
  parameter int LZB            = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_7seg_scan_if.slave  bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic POL = (SEG_ACTIVE_LOW != 0);

  logic [4*N_DIGITS-1:0] disp;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic [N_DIGITS-1:0]   keep;

  logic [N_DIGITS-1:0]   lz;
  logic                  run;
  logic                  active;
  logic [3:0]            nib;
  logic [6:0]            seg_n;
  logic [N_DIGITS-1:0]   an_n;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h40;
    endcase
    return g;
  endfunction

`ifdef BCD_7SEG_SCAN_DP_EN
  logic dp_q;
  logic dp_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep <= '0;
      dp_q <= POL;
    end else begin
      if (bus.load) keep <= bus.dp_in;
      dp_q <= dp_n ^ POL;
    end
  end

  assign dp_n   = active & keep[idx];
  assign bus.dp = dp_q;
`else
  assign keep = '0;
`endif

  // Blank run walks down from the MSD; a dp-marked digit breaks it.
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run   = run & (disp[4*k +: 4] == 4'd0) & ~keep[k];
      lz[k] = run & (k != 0) & (LZB != 0);
    end
  end

  always_comb begin
    active = (cnt >= BLK_END);
    nib    = disp[{idx, 2'b00} +: 4];
    seg_n  = '0;
    an_n   = '0;
    if (active) begin
      an_n[idx] = 1'b1;
      seg_n     = lz[idx] ? 7'h00 : glyph(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp  <= '0;
      cnt   <= '0;
      idx   <= '0;
      seg_q <= {7{POL}};
      an_q  <= {N_DIGITS{POL}};
    end else begin
      if (bus.load) disp <= bus.bcd_in;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg_q <= seg_n ^ {7{POL}};
      an_q  <= an_n ^ {N_DIGITS{POL}};
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = idx;
endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench: three scan drivers (LZB off, LZB on, LZB on + active-low).
// Expected values are hand-derived from slot timing and the decode table.
module tb_bcd_7seg_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dpi = '0;
  int          total = 0;
  int          bad = 0;
  int          e = 0;

  always #5 clk = ~clk;

  bcd_7seg_scan_if #(.N_DIGITS(4)) ia ();
  bcd_7seg_scan_if #(.N_DIGITS(4)) ib ();
  bcd_7seg_scan_if #(.N_DIGITS(4)) ic ();

  assign ia.load = load;
  assign ib.load = load;
  assign ic.load = load;
  assign ia.bcd_in = bcd;
  assign ib.bcd_in = bcd;
  assign ic.bcd_in = bcd;
`ifdef BCD_7SEG_SCAN_DP_EN
  assign ia.dp_in = dpi;
  assign ib.dp_in = dpi;
  assign ic.dp_in = dpi;
`endif

  bcd_7seg_scan #(
    .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(1),
    .LZB(0), .SEG_ACTIVE_LOW(0)
  ) ua (.clk(clk), .rst_n(rst_n), .bus(ia));

  bcd_7seg_scan #(
    .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(1),
    .LZB(1), .SEG_ACTIVE_LOW(0)
  ) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

  bcd_7seg_scan #(
    .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(1),
    .LZB(1), .SEG_ACTIVE_LOW(1)
  ) uc (.clk(clk), .rst_n(rst_n), .bus(ic));

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // e counts rising edges since the last reset release
  task automatic adv_to(input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  initial begin
    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_seg", 16'(ia.seg), 16'h00);
    chk("rst_a_an", 16'(ia.an), 16'h0);
    chk("rst_a_idx", 16'(ia.digit_idx), 16'h0);
    chk("rst_c_seg", 16'(ic.seg), 16'h7F);
    chk("rst_c_an", 16'(ic.an), 16'hF);
    rst_n = 1'b1;
    e = 0;
    adv_to(1);
    chk("e1_blank_an", 16'(ia.an), 16'h0);
    adv_to(2);
    chk("e2_a_an", 16'(ia.an), 16'h1);
    chk("e2_a_seg", 16'(ia.seg), 16'h3F);
    chk("e2_b_seg", 16'(ib.seg), 16'h3F);
    chk("e2_idx", 16'(ia.digit_idx), 16'h0);

    // 2: scan timing with 4321
    bcd  = 16'h4321;
    load = 1'b1;
    adv_to(3);
    load = 1'b0;
    chk("ld_old_seg", 16'(ia.seg), 16'h3F);
    adv_to(4);
    chk("ld_new_seg", 16'(ia.seg), 16'h06);
    adv_to(8);
    chk("d0_end_an", 16'(ia.an), 16'h1);
    adv_to(9);
    chk("d1_blank_an", 16'(ia.an), 16'h0);
    chk("d1_idx", 16'(ia.digit_idx), 16'h1);
    adv_to(10);
    chk("d1_an", 16'(ia.an), 16'h2);
    chk("d1_seg", 16'(ia.seg), 16'h5B);
    adv_to(17);
    chk("d2_blank_an", 16'(ia.an), 16'h0);
    adv_to(18);
    chk("d2_an", 16'(ia.an), 16'h4);
    chk("d2_seg", 16'(ia.seg), 16'h4F);
    adv_to(26);
    chk("d3_an", 16'(ia.an), 16'h8);
    chk("d3_seg", 16'(ia.seg), 16'h66);
    chk("d3_b_seg", 16'(ib.seg), 16'h66);
    adv_to(33);
    chk("wrap_blank_an", 16'(ia.an), 16'h0);
    adv_to(34);
    chk("wrap_an", 16'(ia.an), 16'h1);
    chk("wrap_seg", 16'(ia.seg), 16'h06);
    chk("wrap_c_an", 16'(ic.an), 16'hE);
    chk("wrap_c_seg", 16'(ic.seg), 16'h79);

    // 3: leading zeros with 0070, then 0000
    bcd  = 16'h0070;
    load = 1'b1;
    adv_to(35);
    load = 1'b0;
    adv_to(36);
    chk("lz_d0_seg", 16'(ib.seg), 16'h3F);
    adv_to(42);
    chk("lz_d1_seg", 16'(ib.seg), 16'h07);
    chk("lz_d1_an", 16'(ib.an), 16'h2);
    adv_to(50);
    chk("lz_d2_seg", 16'(ib.seg), 16'h00);
    chk("lz_d2_an", 16'(ib.an), 16'h4);
    chk("nolz_d2_seg", 16'(ia.seg), 16'h3F);
    adv_to(58);
    chk("lz_d3_seg", 16'(ib.seg), 16'h00);
    chk("lz_d3_an", 16'(ib.an), 16'h8);
    chk("lz_c_d3_seg", 16'(ic.seg), 16'h7F);
    chk("lz_c_d3_an", 16'(ic.an), 16'h7);
    bcd  = 16'h0000;
    load = 1'b1;
    adv_to(59);
    load = 1'b0;
    adv_to(66);
    chk("z_d0_seg", 16'(ib.seg), 16'h3F);
    adv_to(74);
    chk("z_d1_seg", 16'(ib.seg), 16'h00);
    chk("z_d1_an", 16'(ib.an), 16'h2);

    // 4: invalid nibble 00B5
    bcd  = 16'h00B5;
    load = 1'b1;
    adv_to(75);
    load = 1'b0;
    adv_to(82);
    chk("inv_d2_seg", 16'(ib.seg), 16'h00);
    adv_to(90);
    chk("inv_d3_seg", 16'(ib.seg), 16'h00);
    adv_to(98);
    chk("inv_d0_seg", 16'(ib.seg), 16'h6D);
    adv_to(106);
    chk("inv_d1_seg", 16'(ib.seg), 16'h40);
    chk("inv_d1_a_seg", 16'(ia.seg), 16'h40);

    // 5: load mid-slot, then reset mid-scan
    adv_to(131);
    chk("mid_pre_seg", 16'(ia.seg), 16'h6D);
    bcd  = 16'h0009;
    load = 1'b1;
    adv_to(132);
    load = 1'b0;
    chk("mid_e1_seg", 16'(ia.seg), 16'h6D);
    adv_to(133);
    chk("mid_e2_seg", 16'(ia.seg), 16'h6F);
    chk("mid_e2_an", 16'(ia.an), 16'h1);
    adv_to(137);
    chk("mid_noreslot", 16'(ia.an), 16'h0);
    adv_to(140);
    chk("pre_rst_idx", 16'(ia.digit_idx), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_seg", 16'(ia.seg), 16'h00);
    chk("arst_a_an", 16'(ia.an), 16'h0);
    chk("arst_idx", 16'(ia.digit_idx), 16'h0);
    chk("arst_c_seg", 16'(ic.seg), 16'h7F);
    chk("arst_c_an", 16'(ic.an), 16'hF);

    // 6: active-low polarity, zeros with dp on digit 1
    bcd  = 16'h0000;
    dpi  = 4'b0010;
    load = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    adv_to(1);
    load = 1'b0;
    adv_to(2);
    chk("pol_d0_seg", 16'(ic.seg), 16'h40);
    chk("pol_d0_an", 16'(ic.an), 16'hE);
`ifdef BCD_7SEG_SCAN_DP_EN
    chk("pol_d0_dp", 16'(ic.dp), 16'h1);
`endif
    adv_to(10);
    chk("pol_d1_an", 16'(ic.an), 16'hD);
`ifdef BCD_7SEG_SCAN_DP_EN
    chk("pol_d1_seg", 16'(ic.seg), 16'h40);
    chk("pol_d1_dp", 16'(ic.dp), 16'h0);
`else
    chk("pol_d1_seg", 16'(ic.seg), 16'h7F);
`endif
    adv_to(18);
    chk("pol_d2_seg", 16'(ic.seg), 16'h7F);
    chk("pol_d2_an", 16'(ic.an), 16'hB);
    adv_to(26);
    chk("pol_d3_seg", 16'(ic.seg), 16'h7F);
    chk("pol_d3_an", 16'(ic.an), 16'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
- Multi-digit, time-multiplexed BCD to 7-segment display driver.
- Latches a packed BCD word on a load strobe and scans one digit at a time onto a shared segment bus.
- Drives per-digit enables, with configurable refresh rate, inter-digit blanking, leading-zero suppression and output polarity.
- Sits between the datapath and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 1000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 1, cycles at the start of each slot with all digit enables off (0 <= BLANK_CYCLES < REFRESH_DIV).
- LZB, 1, 1 = blank leading zeros; 0 = show all digits.
- SEG_ACTIVE_LOW, 1, 1 = seg and an outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture bcd_in into the display register this cycle.
- bcd_in  in  4*N_DIGITS  packed BCD; nibble k = digit k, digit 0 least significant.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- an  out  N_DIGITS  digit enables, bit k = digit k, registered.
- digit_idx  out  clog2(N_DIGITS) (min 1)  index of the digit currently in its slot.

Behaviour:
- Reset is asynchronous on rst_n low:
  - display register cleared to 0.
  - refresh counter and digit_idx cleared to 0.
  - seg and an driven to the inactive level for the chosen polarity: all 1 if SEG_ACTIVE_LOW, all 0 otherwise.
- Reset asserted mid-scan forces these values immediately.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
- On the wrap, digit_idx advances by 1 modulo N_DIGITS: N_DIGITS-1 goes to 0.
- Load:
  - load=1 at a rising edge captures bcd_in into the display register.
  - load does not reset the refresh counter or digit_idx.
  - load held high recaptures on every cycle.
- Outputs are registered with one cycle of latency. At each edge, seg and an are computed from the pre-edge values of the counter, digit_idx and the display register.
- Load to visible change is 2 edges, provided the loaded digit is in its active window.
- Digit enable: an has a single active bit, bit digit_idx, when counter >= BLANK_CYCLES. Otherwise all of an is inactive.
- Decode (active-high form, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Invalid nibble (A-F) shows a dash: 40, segment g only.
- Leading-zero blanking (LZB=1):
  - Digit k (k>0) shows blank (00) when it and every more significant digit equal 0.
  - Digit 0 is never blanked.
  - An invalid nibble is not zero, so it ends the blanking run.
- Blank and dash still drive the digit's an bit as active. Only seg is blanked.
- Polarity: when SEG_ACTIVE_LOW=1, both seg and an are bitwise inverted relative to the active-high form.
- N_DIGITS=1: digit_idx is held at 0; the wrap still occurs but the index does not change.

Optional Feature:
- Macro: BCD_7SEG_SCAN_DP_EN.
- When defined:
  - Adds input dp_in [N_DIGITS-1:0] and output dp, 1 bit, registered.
  - dp_in is captured with bcd_in on load.
  - dp = dp_in bit digit_idx during the active window, and inactive during blanking and reset.
  - dp follows SEG_ACTIVE_LOW polarity.
  - A digit with its dp bit set is exempt from leading-zero blanking, so it shows "0.".
- When undefined: no dp ports and no dp storage; behaviour is identical otherwise.

Test Plan:
All cases use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0 unless noted.
1. Reset: hold rst_n=0 and toggle clk. Expect seg=00, an=0000, digit_idx=0. Release reset and apply no load: after the 2nd edge, an=0001, seg=3F.
2. Scan timing: load bcd_in=16'h4321, LZB=0.
   - Digit slots rotate every 8 cycles with an=0001, 0010, 0100, 1000.
   - seg per slot = 06, 5B, 4F, 66.
   - an=0000 for exactly 1 cycle at each slot start.
   - Wrap from 1000 back to 0001.
3. Leading zeros: LZB=1, bcd_in=16'h0070. Digits 3 and 2 give seg=00 (an still active), digit 1 gives 07, digit 0 gives 3F. Then load 16'h0000: only digit 0 shows 3F.
4. Invalid code: bcd_in=16'h00B5, LZB=1. Digit 1 gives seg=40 and digit 0 gives 6D. Digits 3 and 2 are blank.
5. Load mid-slot and reset mid-scan:
   - During digit 0's active window, load 16'h0009 → seg=6F exactly 2 edges later, with no slot restart.
   - Drop rst_n mid-slot → outputs go inactive asynchronously, and digit_idx=0.
6. Polarity and dp: SEG_ACTIVE_LOW=1, BCD_7SEG_SCAN_DP_EN defined, bcd_in=16'h0000, dp_in=4'b0010.
   - Digit 1 gives seg=~3F=40, dp=0, an=1101.
   - Digit 0 gives seg=40, dp=1.
   - Digits 3 and 2 give seg=7F.
